// File: rtl/mcm_pipe.sv
// mcm_pipe: two-stage shift-and-add multiple-constant multiplier with per-product saturation
// and valid/ready flow control.
module mcm_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*IN_W-1:0]      in_x,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*13*OUT_W-1:0]  out_y,
    output logic                       out_sat
);
    localparam int W = IN_W + 6;
    localparam int E = (W > OUT_W ? W : OUT_W) + 1;
    localparam logic signed [E-1:0] SAT_HI = {{(E-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [E-1:0] SAT_LO = ~SAT_HI;

    logic                       r_live, r_v1, r_v2, r_sat;
    logic [LANES*13*OUT_W-1:0]  r_y;
    logic [LANES*13*OUT_W-1:0]  w_y;
    logic [LANES*13-1:0]        w_clip;
    logic                       w_adv2, w_acc;

    assign w_adv2    = !r_v2 || out_ready;
    // r_live keeps in_ready low until the first edge after reset release
    assign in_ready  = r_live && !flush && (!r_v1 || w_adv2);
    assign w_acc     = in_valid && in_ready;
    assign out_valid = r_v2;
    assign out_y     = r_y;
    assign out_sat   = r_sat;

    genvar l, k;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            logic signed [W-1:0] w_x;
            logic signed [W-1:0] r_m [7];
            logic signed [W-1:0] w_p [13];
            assign w_x = signed'(W'(in_x[l*IN_W +: IN_W]));
            // r_m holds x, 2x, 3x, 4x, 5x, 8x, 16x
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_m <= '{default: '0};
                end else if (w_acc) begin
                    r_m[0] <= w_x;
                    r_m[1] <= w_x <<< 1;
                    r_m[2] <= w_x + (w_x <<< 1);
                    r_m[3] <= w_x <<< 2;
                    r_m[4] <= w_x + (w_x <<< 2);
                    r_m[5] <= w_x <<< 3;
                    r_m[6] <= w_x <<< 4;
                end
            end
            always_comb begin
                w_p[0]  = -r_m[0];
                w_p[1]  = -r_m[2];
                w_p[2]  = -r_m[4];
                w_p[3]  = -r_m[3];
                w_p[4]  = -r_m[1];
                w_p[5]  = r_m[6] - r_m[0];
                w_p[6]  = r_m[6] - r_m[2];
                w_p[7]  = r_m[5] + r_m[2];
                w_p[8]  = r_m[5] + r_m[0];
                w_p[9]  = r_m[5] - r_m[0];
                w_p[10] = r_m[4];
                w_p[11] = r_m[2];
                w_p[12] = r_m[0];
            end
            for (k = 0; k < 13; k++) begin : g_coef
                logic signed [E-1:0] w_e;
                assign w_e = E'(w_p[k]);
                assign w_clip[l*13+k] = (w_e > SAT_HI) || (w_e < SAT_LO);
                assign w_y[(l*13+k)*OUT_W +: OUT_W] = (w_e > SAT_HI) ? SAT_HI[OUT_W-1:0] :
                                                      (w_e < SAT_LO) ? SAT_LO[OUT_W-1:0] :
                                                      w_e[OUT_W-1:0];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_y    <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_v1 <= 1'b0;
                r_v2 <= 1'b0;
            end else begin
                if (w_adv2) begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_y   <= w_y;
                        r_sat <= |w_clip;
                    end
                end
                if (!r_v1 || w_adv2) r_v1 <= w_acc;
            end
        end
    end
endmodule

// File: tb/tb_mcm_pipe.sv
// tb_mcm_pipe: directed checks of mcm_pipe at OUT_W=16 and OUT_W=10 sharing one input stream.
module tb_mcm_pipe;
    logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
    logic [31:0] in_x = '0;
    logic in_ready, out_valid, out_sat;
    logic [4*13*16-1:0] out_y;
    logic a_ready, a_valid, a_sat;
    logic [4*13*10-1:0] a_y;
    int n_cmp = 0, n_fail = 0;
    int c_tab [13] = '{-1, -3, -5, -4, -2, 15, 13, 11, 9, 7, 5, 3, 1};

    mcm_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
                  .in_x(in_x), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
                  .out_y(out_y), .out_sat(out_sat));
    mcm_pipe #(.OUT_W(10)) dut10 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
                  .in_x(in_x), .flush(flush), .out_valid(a_valid), .out_ready(out_ready),
                  .out_y(a_y), .out_sat(a_sat));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int y16(int l, int k);
        return int'($signed(out_y[(l*13+k)*16 +: 16]));
    endfunction

    function automatic int y10(int l, int k);
        return int'($signed(a_y[(l*13+k)*10 +: 10]));
    endfunction

    function automatic int model(int k, int x, int ow);
        int p, hi, lo;
        p  = c_tab[k] * x;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        return p > hi ? hi : (p < lo ? lo : p);
    endfunction

    function automatic logic [31:0] all4(int x);
        logic [7:0] b;
        b = 8'(x);
        return {b, b, b, b};
    endfunction

    task automatic test_reset();
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
        n_cmp++; if (out_y !== '0) begin n_fail++; $display("FAIL rst_y got %h want 0", out_y); end
        n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat got %b want 0", out_sat); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", in_ready); end
        tick();
        tick();
        rst_n = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_pre got %b want 0", in_ready); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready_post got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        in_x = all4(255); in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", out_valid); end
        n_cmp++; if (y16(0, 5) !== 3825) begin n_fail++; $display("FAIL k5 got %0d want 3825", y16(0, 5)); end
        n_cmp++; if (y16(0, 6) !== 3315) begin n_fail++; $display("FAIL k6 got %0d want 3315", y16(0, 6)); end
        n_cmp++; if (out_y[2*16 +: 16] !== 16'hFB05) begin n_fail++; $display("FAIL k2 got %h want fb05", out_y[2*16 +: 16]); end
        n_cmp++; if (y16(0, 0) !== -255) begin n_fail++; $display("FAIL k0 got %0d want -255", y16(0, 0)); end
        n_cmp++; if (y16(0, 12) !== 255) begin n_fail++; $display("FAIL k12 got %0d want 255", y16(0, 12)); end
        n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL sat255 got %b want 0", out_sat); end
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 13; k++) begin
                n_cmp++;
                if (y16(l, k) !== model(k, 255, 16)) begin
                    n_fail++; $display("FAIL p255 l%0d k%0d got %0d want %0d", l, k, y16(l, k), model(k, 255, 16));
                end
            end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_beat got %b want 0", out_valid); end
    endtask

    task automatic test_sat();
        in_x = all4(100); in_valid = 1;
        tick();
        in_x = all4(10);
        tick();
        in_valid = 0;
        n_cmp++; if (y10(0, 5) !== 511) begin n_fail++; $display("FAIL s_k5 got %0d want 511", y10(0, 5)); end
        n_cmp++; if (y10(0, 6) !== 511) begin n_fail++; $display("FAIL s_k6 got %0d want 511", y10(0, 6)); end
        n_cmp++; if (y10(0, 7) !== 511) begin n_fail++; $display("FAIL s_k7 got %0d want 511", y10(0, 7)); end
        n_cmp++; if (y10(0, 2) !== -500) begin n_fail++; $display("FAIL s_k2 got %0d want -500", y10(0, 2)); end
        n_cmp++; if (y10(0, 3) !== -400) begin n_fail++; $display("FAIL s_k3 got %0d want -400", y10(0, 3)); end
        n_cmp++; if (a_sat !== 1'b1) begin n_fail++; $display("FAIL s_sat got %b want 1", a_sat); end
        n_cmp++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL s_sat16 got %b want 0", out_sat); end
        n_cmp++; if (y16(0, 5) !== 1500) begin n_fail++; $display("FAIL s_k5_16 got %0d want 1500", y16(0, 5)); end
        tick();
        n_cmp++; if (y10(0, 5) !== 150) begin n_fail++; $display("FAIL s10_k5 got %0d want 150", y10(0, 5)); end
        n_cmp++; if (a_sat !== 1'b0) begin n_fail++; $display("FAIL s10_sat got %b want 0", a_sat); end
        tick();
    endtask

    task automatic test_lanes();
        int xs [4] = '{1, 7, 200, 0};
        in_x = {8'd0, 8'd200, 8'd7, 8'd1}; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 13; k++) begin
                n_cmp++;
                if (y16(l, k) !== model(k, xs[l], 16)) begin
                    n_fail++; $display("FAIL lane16 l%0d k%0d got %0d want %0d", l, k, y16(l, k), model(k, xs[l], 16));
                end
                n_cmp++;
                if (y10(l, k) !== model(k, xs[l], 10)) begin
                    n_fail++; $display("FAIL lane10 l%0d k%0d got %0d want %0d", l, k, y10(l, k), model(k, xs[l], 10));
                end
            end
        n_cmp++; if (a_sat !== 1'b1) begin n_fail++; $display("FAIL lane_sat got %b want 1", a_sat); end
        tick();
    endtask

    task automatic test_stream();
        int sent = 0, got = 0;
        logic stalled = 0;
        logic [4*13*16-1:0] held = '0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            in_valid = (sent < 20);
            in_x = all4(sent + 1);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                n_cmp++;
                if (!out_valid || out_y !== held) begin
                    n_fail++; $display("FAIL stall_hold got v=%b y5=%0d want held y5=%0d", out_valid, y16(0, 5), int'($signed(held[5*16 +: 16])));
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (y16(0, 5) !== 15 * (got + 1)) begin
                    n_fail++; $display("FAIL stream_order got %0d want %0d", y16(0, 5), 15 * (got + 1));
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held = out_y;
            if (in_valid && in_ready) sent++;
            tick();
        end
        n_cmp++; if (got !== 20) begin n_fail++; $display("FAIL stream_count got %0d want 20", got); end
        in_valid = 0; out_ready = 1;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_dup got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4*13*16-1:0] held;
        out_ready = 0; in_valid = 1; in_x = all4(30);
        tick();
        in_x = all4(31);
        tick();
        in_x = all4(32);
        held = out_y;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready c%0d got %b want 0", c, in_ready); end
            n_cmp++;
            if (out_valid !== 1'b1 || out_y !== held || y16(0, 5) !== 450) begin
                n_fail++; $display("FAIL full_hold c%0d got v=%b y5=%0d want v=1 y5=450", c, out_valid, y16(0, 5));
            end
            tick();
        end
        out_ready = 1;
        for (int j = 0; j < 5; j++) begin
            in_valid = (j < 3);
            in_x = all4(32 + j);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || y16(0, 5) !== 15 * (30 + j)) begin
                n_fail++; $display("FAIL b2b j%0d got v=%b y5=%0d want v=1 y5=%0d", j, out_valid, y16(0, 5), 15 * (30 + j));
            end
            if (j < 3) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready j%0d got %b want 1", j, in_ready); end
            end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1; in_valid = 1; in_x = all4(40);
        tick();
        in_x = all4(41);
        tick();
        flush = 1; in_x = all4(42);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", in_ready); end
        tick();
        flush = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
        in_x = all4(43);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_flush_ready got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_flush_early got %b want 0", out_valid); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || y16(0, 5) !== 645) begin
            n_fail++; $display("FAIL post_flush_beat got v=%b y5=%0d want v=1 y5=645", out_valid, y16(0, 5));
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak got %b want 0", out_valid); end
    endtask

    task automatic test_midreset();
        out_ready = 1; in_valid = 1; in_x = all4(50);
        tick();
        in_x = all4(51);
        tick();
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", out_valid); end
        n_cmp++; if (out_y !== '0) begin n_fail++; $display("FAIL mid_y got y5=%0d want 0", y16(0, 5)); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b want 0", in_ready); end
        in_valid = 0;
        tick();
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_leak c%0d got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_lanes();
        test_stream();
        test_back_to_back();
        test_flush();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
